// File: rtl/pll_cal_pkg.sv
// Shared types and helpers for the PLL trim calibrator.
// Latency: none (package only).
// Backpressure: not applicable.
package pll_cal_pkg;

    localparam int TRIM_W = 26;
    localparam int LVL_W  = $clog2(TRIM_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        EVAL,
        DONE
    } cal_state_t;

    // Level L sets bits [L-1:0]; level 0 is all zeros.
    function automatic logic [TRIM_W-1:0] thermo(input logic [LVL_W-1:0] level);
        logic [TRIM_W-1:0] t;
        t = '0;
        for (int i = 0; i < TRIM_W; i++) begin
            t[i] = (i < int'(level));
        end
        return t;
    endfunction

endpackage

// File: rtl/pll_tick_window_counter.sv
// Counts feedback ticks over a fixed window of clock cycles, saturating.
// Latency: count reflects a tick one cycle after it is sampled; window_done is combinational from state.
// Backpressure: none; ticks arriving while en is low are dropped.
module pll_tick_window_counter #(
    parameter int CNT_W  = 12,
    parameter int WINDOW = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             fb_tick,
    output logic [CNT_W-1:0] count,
    output logic             window_done
);
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [WIN_W-1:0] win;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
            win   <= WIN_W'(WINDOW - 1);
        end else if (en) begin
            if (fb_tick && (count != '1)) begin
                count <= count + 1'b1;
            end
            if (win != '0) begin
                win <= win - 1'b1;
            end
        end
    end

    // Asserted during the last window cycle, whose tick is still counted.
    assign window_done = en && (win == '0);

endmodule

// File: rtl/pll_trim_calibrator.sv
// Binary-search calibration of the ring-oscillator trim against a tick-count target.
// Latency: SETTLE_CYC + WINDOW + 1 cycles per evaluation, at most 5 evaluations.
// Backpressure: start is ignored while busy; results are held until the next start.
module pll_trim_calibrator
    import pll_cal_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int WINDOW     = 64,
    parameter int SETTLE_CYC = 8,
    parameter int TOL        = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  target,
    input  logic              fb_tick,
    output logic              dco,
    output logic [TRIM_W-1:0] ext_trim,
    output logic [CNT_W-1:0]  meas_count,
    output logic              busy,
    output logic              locked,
    output logic              fail
);
    localparam int SC_W = $clog2(SETTLE_CYC + 1);
    localparam logic [LVL_W-1:0] MID0 = LVL_W'(TRIM_W >> 1);

    cal_state_t       state;
    logic [SC_W-1:0]  settle_cnt;
    logic [LVL_W-1:0] lo, hi, mid, best_lvl;
    logic [CNT_W-1:0] best_err;

    logic [CNT_W-1:0] count;
    logic             window_done;

    pll_tick_window_counter #(
        .CNT_W  (CNT_W),
        .WINDOW (WINDOW)
    ) u_counter (
        .clock       (clock),
        .reset       (reset),
        .clear       (state == SETTLE),
        .en          (state == MEASURE),
        .fb_tick     (fb_tick),
        .count       (count),
        .window_done (window_done)
    );

    logic [CNT_W-1:0] err;
    logic             better;
    logic             finish;
    logic [LVL_W-1:0] lo_n, hi_n, mid_n, best_lvl_n;
    logic [LVL_W:0]   range_sum;

    // Higher trim level is slower: too many ticks moves the search upward.
    always_comb begin
        err        = (count > target) ? (count - target) : (target - count);
        better     = (err < best_err);
        best_lvl_n = better ? mid : best_lvl;
        lo_n       = lo;
        hi_n       = hi;
        finish     = 1'b0;
        if (count > target) begin
            lo_n   = mid + 1'b1;
            finish = (lo_n > hi);
        end else if (mid == lo) begin
            finish = 1'b1;
        end else begin
            hi_n = mid - 1'b1;
        end
        range_sum = {1'b0, lo_n} + {1'b0, hi_n};
        mid_n     = range_sum[LVL_W:1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            lo         <= '0;
            hi         <= '0;
            mid        <= '0;
            best_lvl   <= '0;
            best_err   <= '1;
            dco        <= 1'b0;
            ext_trim   <= '0;
            meas_count <= '0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lo         <= '0;
                        hi         <= LVL_W'(TRIM_W);
                        mid        <= MID0;
                        best_lvl   <= MID0;
                        best_err   <= '1;
                        locked     <= 1'b0;
                        fail       <= 1'b0;
                        ext_trim   <= thermo(MID0);
                        dco        <= 1'b1;
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SC_W'(SETTLE_CYC - 1)) begin
                        state <= MEASURE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (window_done) begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    meas_count <= count;
                    best_lvl   <= best_lvl_n;
                    if (better) begin
                        best_err <= err;
                    end
                    if (err <= CNT_W'(TOL)) begin
                        locked <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end else if (finish) begin
                        ext_trim <= thermo(best_lvl_n);
                        fail     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        lo         <= lo_n;
                        hi         <= hi_n;
                        mid        <= mid_n;
                        ext_trim   <= thermo(mid_n);
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_trim_calibrator.sv
// Bench: DCO model gives 60-2*level ticks per window; scoreboard checks each completed calibration.
module tb_pll_trim_calibrator;
    localparam int TW = 26;
    localparam int CW = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] target = '0;
    logic          fb_tick = 1'b0;
    logic          dco, busy, locked, fail;
    logic [TW-1:0] ext_trim;
    logic [CW-1:0] meas_count;

    logic          start_s = 1'b0;
    logic [5:0]    target_s = 6'd63;
    logic          dco_s, busy_s, locked_s, fail_s;
    logic [TW-1:0] ext_trim_s;
    logic [5:0]    meas_s;

    always #5 clock = ~clock;

    pll_trim_calibrator dut (
        .clock(clock), .reset(reset), .start(start), .target(target), .fb_tick(fb_tick),
        .dco(dco), .ext_trim(ext_trim), .meas_count(meas_count),
        .busy(busy), .locked(locked), .fail(fail)
    );

    pll_trim_calibrator #(.CNT_W(6)) dut_sat (
        .clock(clock), .reset(reset), .start(start_s), .target(target_s), .fb_tick(1'b1),
        .dco(dco_s), .ext_trim(ext_trim_s), .meas_count(meas_s),
        .busy(busy_s), .locked(locked_s), .fail(fail_s)
    );

    typedef struct packed {
        logic          lk;
        logic          fl;
        logic [TW-1:0] trim;
        logic [CW-1:0] meas;
        logic [2:0]    n;
        logic [24:0]   lvls;
        logic [9:0]    cyc;
    } exp_t;

    exp_t exp_q[$];
    int   sat_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic exp_t mk(input bit lk, input bit fl, input logic [TW-1:0] trim,
                                input int meas, input int n, input int l0, input int l1,
                                input int l2, input int l3, input int l4, input int cyc);
        exp_t e;
        e.lk   = lk;
        e.fl   = fl;
        e.trim = trim;
        e.meas = CW'(meas);
        e.n    = 3'(n);
        e.lvls = {5'(l4), 5'(l3), 5'(l2), 5'(l1), 5'(l0)};
        e.cyc  = 10'(cyc);
        return e;
    endfunction

    // DCO model: ticks fill the first 60-2*level cycles of the measurement window.
    initial begin
        int            phase = 0;
        logic [TW-1:0] last_trim = '0;
        logic          last_busy = 1'b0;
        int            nt;
        forever begin
            @(posedge clock);
            #1;
            if (ext_trim != last_trim || (busy && !last_busy)) phase = 0;
            else if (phase < 10000) phase++;
            last_trim = ext_trim;
            last_busy = busy;
            nt = 60 - 2 * $countones(ext_trim);
            fb_tick = (phase >= 8) && (phase < 8 + nt);
        end
    end

    // Monitor: tracks visited levels and duration, compares on each completion.
    initial begin
        logic          prev_busy = 1'b0;
        logic [TW-1:0] last_trim = '0;
        logic [24:0]   lvls = '0;
        int            n = 0;
        int            cyc = 0;
        exp_t          e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset) begin
                if (busy && !prev_busy) begin
                    n = 1;
                    lvls = '0;
                    lvls[4:0] = 5'($countones(ext_trim));
                    cyc = 0;
                end else if (busy) begin
                    cyc++;
                    if (ext_trim != last_trim && n < 5) begin
                        lvls[5*n +: 5] = 5'($countones(ext_trim));
                        n++;
                    end
                end else if (prev_busy) begin
                    cyc++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("locked", locked, e.lk);
                        chk("fail", fail, e.fl);
                        chk("ext_trim", ext_trim, e.trim);
                        chk("meas_count", meas_count, e.meas);
                        chk("num_evals", n, e.n);
                        chk("levels", lvls, e.lvls);
                        chk("cycles", cyc, e.cyc);
                        chk("dco_held", dco, 1);
                    end
                end
                last_trim = ext_trim;
            end
            prev_busy = busy;
        end
    end

    initial begin
        logic prev_s = 1'b0;
        int   e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && prev_s && !busy_s) begin
                if (sat_q.size() == 0) begin
                    chk("sat_unexpected_done", sat_q.size(), 1);
                end else begin
                    e = sat_q.pop_front();
                    chk("sat_meas_count", meas_s, e);
                    chk("sat_locked", locked_s, 1);
                end
            end
            prev_s = busy_s;
        end
    end

    task automatic pulse_start(input int t);
        @(negedge clock);
        target = CW'(t);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (busy && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_dco", dco, 0);
        chk("rst_ext_trim", ext_trim, 0);
        chk("rst_meas_count", meas_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fail", fail, 0);
        reset = 1'b0;
        @(negedge clock);

        // Immediate lock at the first level.
        exp_q.push_back(mk(1, 0, 26'h0001FFF, 34, 1, 13, 0, 0, 0, 0, 73));
        pulse_start(34);
        wait_done("done_t34");

        // Full search, with a start pulse during SETTLE that must be ignored.
        exp_q.push_back(mk(1, 0, 26'h00003FF, 40, 5, 13, 6, 9, 11, 10, 365));
        pulse_start(40);
        repeat (2) @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done("done_t40");

        // Restart from DONE with an unreachable target.
        exp_q.push_back(mk(0, 1, 26'h0000000, 60, 4, 13, 6, 2, 0, 0, 292));
        pulse_start(70);
        wait_done("done_t70");

        // Reset during the second iteration's measurement window.
        pulse_start(40);
        repeat (100) @(negedge clock);
        chk("mid_meas_count", meas_count, 34);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("mrst_dco", dco, 0);
        chk("mrst_ext_trim", ext_trim, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_meas_count", meas_count, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_fail", fail, 0);
        reset = 1'b0;
        @(negedge clock);

        exp_q.push_back(mk(1, 0, 26'h0001FFF, 34, 1, 13, 0, 0, 0, 0, 73));
        pulse_start(34);
        wait_done("done_after_reset");

        // Saturation: tick every cycle into a 6-bit counter.
        sat_q.push_back(63);
        @(negedge clock);
        start_s = 1'b1;
        @(negedge clock);
        start_s = 1'b0;
        begin
            int k = 0;
            while (busy_s && k < 2000) begin
                @(negedge clock);
                k++;
            end
            chk("done_sat", busy_s, 0);
        end

        repeat (4) @(negedge clock);
        chk("exp_queue_empty", exp_q.size(), 0);
        chk("sat_queue_empty", sat_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
